// File: rtl/bitmap_encoder_8x3.sv
// Serialises a multi-hot 8-bit bitmap into ascending 3-bit indices, one per output handshake.
// An all-zero bitmap is consumed without producing a beat and flagged on zero_drop.
module bitmap_encoder_8x3 #(
    parameter int unsigned SIZE_IN  = 8,
    parameter int unsigned SIZE_OUT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE_IN-1:0]  in_vec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZE_OUT-1:0] out_idx,
    output logic                out_last,
    output logic                zero_drop
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state;
    logic [SIZE_IN-1:0]  pending;
    logic [SIZE_IN-1:0]  pending_rest;

    // Clearing the lowest set bit is exactly clearing the bit at out_idx.
    assign pending_rest = pending & (pending - SIZE_IN'(1));

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == EMIT);
    assign out_last  = (pending != '0) && (pending_rest == '0);

    // Lowest set bit wins; scanning downward lets the lowest index overwrite.
    always_comb begin
        out_idx = '0;
        for (int i = SIZE_IN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                out_idx = SIZE_OUT'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            zero_drop <= 1'b0;
        end else begin
            zero_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_vec != '0) begin
                            pending <= in_vec;
                            state   <= EMIT;
                        end else begin
                            zero_drop <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            pending <= '0;
                            state   <= IDLE;
                        end else begin
                            pending <= pending_rest;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitmap_encoder_8x3.sv
// Scoreboard bench for bitmap_encoder_8x3: expected beats are queued when a bitmap is
// driven and popped by a negedge monitor on every output handshake.
module tb_bitmap_encoder_8x3;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_vec = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_idx;
    logic       out_last;
    logic       zero_drop;

    int    checks = 0;
    int    errors = 0;
    int    beats  = 0;
    int    vcnt   = 0;
    int    rmode  = 0;
    logic  tog    = 1'b1;
    beat_t q[$];

    bitmap_encoder_8x3 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_drop (zero_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // out_ready pattern: 0 always high, 1 random, 2 toggling, other held low.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       begin out_ready = tog; tog = ~tog; end
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on handshakes and checks stall stability.
    logic       pstall = 1'b0;
    logic [2:0] pidx;
    logic       plast;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            pstall = 1'b0;
        end else begin
            if (pstall) begin
                check("hold_valid", 32'(out_valid), 32'(1));
                check("hold_idx", 32'(out_idx), 32'(pidx));
                check("hold_last", 32'(out_last), 32'(plast));
            end
            if (out_valid) vcnt++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("beat_idx", 32'(out_idx), 32'(e.idx));
                    check("beat_last", 32'(out_last), 32'(e.last));
                    beats++;
                end
            end
            pstall = out_valid && !out_ready;
            pidx   = out_idx;
            plast  = out_last;
        end
    end

    function automatic int popcnt(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) n++;
        return n;
    endfunction

    // Drive one bitmap for one cycle; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] v);
        int    n;
        int    k;
        beat_t b;
        n = popcnt(v);
        k = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_vec   = v;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                k++;
                b.idx  = 3'(i);
                b.last = (k == n);
                q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec   = 8'($urandom);
        @(negedge clk);
        check("accept_zero_drop", 32'(zero_drop), 32'(v == 8'h00));
        check("accept_out_valid", 32'(out_valid), 32'(v != 8'h00));
        check("accept_in_ready", 32'(in_ready), 32'(v == 8'h00));
        if (v == 8'h00) begin
            @(negedge clk);
            check("zero_drop_pulse", 32'(zero_drop), 32'(0));
            check("zero_no_valid", 32'(out_valid), 32'(0));
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        forever begin
            #1;
            if (in_ready && q.size() == 0) break;
            if (cyc >= 300) begin
                check("idle_timeout", 32'(cyc), 32'(0));
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int b0;
        int v0;
        int n;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_idx", 32'(out_idx), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_zero_drop", 32'(zero_drop), 32'(0));
        #11 rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'(1));

        // A5 with out_ready high: four back-to-back beats
        rmode = 0;
        repeat (2) @(posedge clk);
        b0 = beats;
        send(8'hA5);
        wait_idle(cyc);
        check("a5_latency", 32'(cyc), 32'(4));
        check("a5_beats", 32'(beats - b0), 32'(4));

        // Single bit with three stall cycles
        rmode = 3;
        repeat (2) @(posedge clk);
        b0 = beats;
        v0 = vcnt;
        send(8'h80);
        repeat (3) @(posedge clk);
        rmode = 0;
        wait_idle(cyc);
        check("stall_valid_cycles", 32'(vcnt - v0), 32'(4));
        check("stall_handshakes", 32'(beats - b0), 32'(1));

        // All-zero bitmap
        send(8'h00);
        check("zero_in_ready", 32'(in_ready), 32'(1));

        // FF with toggling out_ready and ignored input mid-burst
        rmode = 2;
        b0 = beats;
        send(8'hFF);
        repeat (3) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_vec   = 8'h0F;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle(cyc);
        repeat (4) @(negedge clk);
        check("ff_beats", 32'(beats - b0), 32'(8));
        check("ff_quiet_after", 32'(out_valid), 32'(0));

        // Asynchronous reset in the middle of a burst
        rmode = 0;
        b0 = beats;
        send(8'h3C);
        n = 0;
        while (beats < b0 + 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("pre_rst_beats", 32'(beats - b0), 32'(2));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_out_idx", 32'(out_idx), 32'(0));
        check("mid_rst_out_last", 32'(out_last), 32'(0));
        check("mid_rst_in_ready", 32'(in_ready), 32'(0));
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #4 rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));
        b0 = beats;
        repeat (3) @(negedge clk);
        check("post_rst_no_beat", 32'(beats - b0), 32'(0));
        send(8'h02);
        wait_idle(cyc);
        check("b02_latency", 32'(cyc), 32'(1));
        check("b02_beats", 32'(beats - b0), 32'(1));

        // All 256 bitmaps with random out_ready
        rmode = 1;
        for (int v = 0; v < 256; v++) begin
            b0 = beats;
            send(8'(v));
            wait_idle(cyc);
            check("sweep_beats", 32'(beats - b0), 32'(popcnt(8'(v))));
        end

        repeat (4) @(negedge clk);
        check("final_queue_empty", 32'(q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/bitmap_encoder_8x3.md
BITMAP_ENCODER_8X3 -- requirements
Module: bitmap_encoder_8x3

Interface
REQ-001 Parameter: SIZE_IN, 8, width of input bitmap (fixed; no other value supported).
REQ-002 Parameter: SIZE_OUT, 3, width of encoded index (fixed).
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  input  1  in_vec holds a bitmap to encode.
REQ-006 Port: in_ready  output  1  block can accept a bitmap this cycle.
REQ-007 Port: in_vec  input  SIZE_IN  bitmap; bit i set means index i is requested.
REQ-008 Port: out_valid  output  1  out_idx/out_last hold a valid beat.
REQ-009 Port: out_ready  input  1  consumer accepts the current beat.
REQ-010 Port: out_idx  output  SIZE_OUT  binary index of the emitted bit.
REQ-011 Port: out_last  output  1  current beat is the final beat of its bitmap.
REQ-012 Port: zero_drop  output  1  one-cycle pulse, accepted bitmap was all-zero.

Function
REQ-013 The block is the inverse of the 3x8 one-hot decoder: it SHALL convert a multi-hot bitmap into a sequence of binary indices, one per output handshake.
REQ-014 Two states SHALL exist: IDLE and EMIT; state SHALL be held in a register together with an 8-bit pending register.
REQ-015 in_ready SHALL equal 1 exactly when state is IDLE and rst is low; in_ready SHALL be 0 in EMIT.
REQ-016 Input accept = in_valid & in_ready, sampled at rising clk.
REQ-017 Accept with in_vec != 0: pending <= in_vec, state <= EMIT.
REQ-018 Accept with in_vec == 0: state stays IDLE, pending unchanged, zero_drop = 1 for exactly the following cycle; no output beat produced.
REQ-019 zero_drop SHALL be registered and 0 in every cycle not covered by REQ-018.
REQ-020 out_valid SHALL be 1 exactly when state is EMIT (registered state decode, no combinational path from in_valid or out_ready).
REQ-021 out_idx SHALL be the index of the lowest-numbered set bit of pending (bit 0 highest priority); 0 when pending is 0.
REQ-022 out_last SHALL be 1 when pending has exactly one bit set, else 0.
REQ-023 Output handshake = out_valid & out_ready; on it, the bit at out_idx SHALL be cleared in pending.
REQ-024 Handshake with out_last = 1: state <= IDLE, pending <= 0.
REQ-025 While out_valid = 1 and out_ready = 0, out_idx, out_last and pending SHALL hold stable.
REQ-026 in_vec and in_valid SHALL be ignored in EMIT; no new bitmap accepted in the same cycle as the last handshake.
REQ-027 Latency: accept at edge N -> first out_valid after edge N; bitmap with k set bits and out_ready held 1 -> k beats on consecutive cycles, in_ready high again after edge N+k.
REQ-028 Beats SHALL be emitted in strictly ascending index order; each set bit emitted exactly once.

Reset
REQ-029 While rst = 1 (asynchronously): state = IDLE, pending = 0, out_valid = 0, out_last = 0, out_idx = 0, zero_drop = 0, in_ready = 0.
REQ-030 After rst deasserts, in_ready = 1 in the same cycle; first accept possible at the next rising edge.
REQ-031 rst asserted during EMIT SHALL discard all pending beats; no beat is emitted after reset release until a new accept.

Verification
REQ-032 in_vec=8'b1010_0101, in_valid 1 cycle, out_ready=1 -> out_idx 0,2,5,7 on four consecutive cycles, out_last=1 only on idx 7, in_ready=1 on the cycle after.
REQ-033 in_vec=8'b1000_0000, out_ready=0 for 3 cycles then 1 -> out_valid held 4 cycles with out_idx=7, out_last=1 stable; one handshake total.
REQ-034 in_vec=8'h00 accepted -> zero_drop=1 for one cycle, out_valid stays 0, in_ready stays 1.
REQ-035 in_vec=8'hFF, out_ready toggled 1,0,1,0,... -> eight beats idx 0..7 in order, values stable across stall cycles; in_vec changed to 8'h0F mid-burst has no effect.
REQ-036 in_vec=8'h3C accepted, rst pulsed (not aligned to clk) after second beat -> all outputs 0 immediately, no further beats; new in_vec=8'h02 after release -> single beat idx 1, out_last=1.
REQ-037 Exhaustive: all 256 in_vec values with random out_ready -> emitted index set equals set bits of in_vec, ascending, out_last on final beat only.
